// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - size encodings, FSM states and byte-strobe helper for dcache_ctrl
package dcache_pkg;

  localparam logic [1:0] WS_BYTE = 2'b00;
  localparam logic [1:0] WS_HALF = 2'b01;
  localparam logic [1:0] WS_WORD = 2'b10;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESP} dcache_state_t;

  // Misaligned half/word accesses are aligned down, so only addr[1] matters for halves.
  function automatic logic [3:0] ws_to_wstrb(input logic [1:0] ws, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (ws)
      WS_BYTE: strb = 4'b0001 << addr_lo;
      WS_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      WS_WORD: strb = 4'b1111;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/dcache_store_align.sv
// rtl/dcache_store_align.sv - store strobes and lane-replicated data from size and address
module dcache_store_align
  import dcache_pkg::*;
(
  input  logic [1:0]  ws,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] lane_data
);

  always_comb begin
    wstrb = ws_to_wstrb(ws, addr_lo);
    case (ws)
      WS_BYTE: lane_data = {4{wdata[7:0]}};
      WS_HALF: lane_data = {2{wdata[15:0]}};
      default: lane_data = wdata;
    endcase
  end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-allocate data cache controller
// Define DCACHE_STATS_EN to add load hit/miss counters (stat_hits, stat_misses).
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NLINES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_wdata,
  input  logic [1:0]  dcache_ws,
  input  logic        dcache_req,
  input  logic        dcache_wr,
  output logic [31:0] dcache_rdata,
  output logic        dcache_rdy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_req,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdy
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);

  localparam int IDXW = $clog2(NLINES);
  localparam int TAGW = 30 - IDXW;

  dcache_state_t   state;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic [1:0]      req_ws;
  logic            req_wr;
  logic [NLINES-1:0] valid;
  logic [TAGW-1:0] tag_mem [NLINES];
  logic [31:0]     data_mem [NLINES];
  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;
  logic            hit;
  logic [3:0]      st_strb;
  logic [31:0]     st_data;
  logic [31:0]     merged;

  assign idx = req_addr[IDXW+1:2];
  assign tag = req_addr[31:IDXW+2];
  assign hit = valid[idx] && (tag_mem[idx] == tag);

  dcache_store_align u_align (
    .ws        (req_ws),
    .addr_lo   (req_addr[1:0]),
    .wdata     (req_wdata),
    .wstrb     (st_strb),
    .lane_data (st_data)
  );

  always_comb begin
    merged = data_mem[idx];
    for (int i = 0; i < 4; i++) begin
      if (st_strb[i]) merged[i*8 +: 8] = st_data[i*8 +: 8];
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone gate hits.
  always_ff @(posedge clock) begin
    if (state == LOOKUP && req_wr && hit) begin
      data_mem[idx] <= merged;
    end else if (state == MEM_RD && mem_rdy) begin
      data_mem[idx] <= mem_rdata;
      tag_mem[idx]  <= tag;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      valid        <= '0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_ws       <= '0;
      req_wr       <= 1'b0;
      dcache_rdy   <= 1'b0;
      dcache_rdata <= '0;
      mem_req      <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
    end else begin
      dcache_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (dcache_req) begin
            req_addr  <= dcache_addr;
            req_wdata <= dcache_wdata;
            req_ws    <= dcache_ws;
            req_wr    <= dcache_wr;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!req_wr && hit) begin
            dcache_rdata <= data_mem[idx];
            dcache_rdy   <= 1'b1;
            state        <= RESP;
          end else begin
            mem_req   <= 1'b1;
            mem_wr    <= req_wr;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wstrb <= req_wr ? st_strb : 4'b0000;
            mem_wdata <= req_wr ? st_data : 32'h0;
            state     <= req_wr ? MEM_WR : MEM_RD;
          end
        end
        MEM_RD: begin
          if (mem_rdy) begin
            mem_req      <= 1'b0;
            valid[idx]   <= 1'b1;
            dcache_rdata <= mem_rdata;
            dcache_rdy   <= 1'b1;
            state        <= RESP;
          end
        end
        MEM_WR: begin
          if (mem_rdy) begin
            mem_req      <= 1'b0;
            mem_wr       <= 1'b0;
            dcache_rdata <= '0;
            dcache_rdy   <= 1'b1;
            state        <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == LOOKUP && !req_wr) begin
      if (hit) stat_hits <= stat_hits + 32'd1;
      else     stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - randomized self-checking bench for dcache_ctrl against a residency/memory model
module tb_dcache_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dcache_addr = '0;
  logic [31:0] dcache_wdata = '0;
  logic [1:0]  dcache_ws = '0;
  logic        dcache_req = 1'b0;
  logic        dcache_wr = 1'b0;
  logic [31:0] dcache_rdata;
  logic        dcache_rdy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_rdata = '0;
  logic        mem_rdy = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  dcache_ctrl #(.NLINES(64)) dut (
    .clock(clock), .reset(reset),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata), .dcache_ws(dcache_ws),
    .dcache_req(dcache_req), .dcache_wr(dcache_wr),
    .dcache_rdata(dcache_rdata), .dcache_rdy(dcache_rdy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
`ifdef DCACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        got_rdy;
    logic [7:0]  cycles;
    logic [31:0] rdata;
    logic        req_at_rdy;
    logic        mem_seen;
    logic [7:0]  mem_first;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        after_ok;
  } obs_t;

  int vectors = 0;
  int miscompares = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  logic [31:0] ref_mem  [int unsigned];
  logic [31:0] phys_mem [int unsigned];
  int unsigned resident [int unsigned];

  function automatic logic [31:0] mem_get(int unsigned w);
    if (!ref_mem.exists(w)) begin
      ref_mem[w]  = $urandom;
      phys_mem[w] = ref_mem[w];
    end
    return ref_mem[w];
  endfunction

  function automatic string fmt(obs_t x);
    return $sformatf("rdy=%0b cyc=%0d rdata=%h req@rdy=%0b mem=%0b@%0d wr=%0b addr=%h strb=%b wdata=%h post=%0b",
                     x.got_rdy, x.cycles, x.rdata, x.req_at_rdy, x.mem_seen, x.mem_first,
                     x.mem_wr, x.mem_addr, x.mem_wstrb, x.mem_wdata, x.after_ok);
  endfunction

  // Expected outcome from cache rules: a line holds one word, loads allocate, stores never do.
  task automatic model_access(input bit wr, input logic [1:0] ws, input logic [31:0] addr,
                              input logic [31:0] wdata, input int d, output obs_t e);
    int unsigned w   = addr >> 2;
    int unsigned idx = w % 64;
    int unsigned lo  = addr % 4;
    logic [31:0] old, data, mask;
    logic [3:0]  strb;
    e = '0;
    e.got_rdy  = 1'b1;
    e.after_ok = 1'b1;
    old = mem_get(w);
    if (!wr) begin
      e.rdata = old;
      if (resident.exists(idx) && resident[idx] == w) begin
        e.cycles = 8'd2;
        exp_hits++;
      end else begin
        e.cycles    = 8'(2 + d);
        e.mem_seen  = 1'b1;
        e.mem_first = 8'd2;
        e.mem_addr  = w * 4;
        resident[idx] = w;
        exp_misses++;
      end
    end else begin
      case (ws)
        2'b00: begin
          strb = 4'd1 << lo;
          data = (wdata & 32'hFF) * 32'h0101_0101;
          mask = 32'hFF << (8 * lo);
        end
        2'b01: begin
          strb = (lo >= 2) ? 4'hC : 4'h3;
          data = (wdata & 32'hFFFF) * 32'h0001_0001;
          mask = (lo >= 2) ? 32'hFFFF_0000 : 32'h0000_FFFF;
        end
        default: begin
          strb = 4'hF;
          data = wdata;
          mask = 32'hFFFF_FFFF;
        end
      endcase
      ref_mem[w]  = (old & ~mask) | (data & mask);
      e.cycles    = 8'(2 + d);
      e.mem_seen  = 1'b1;
      e.mem_first = 8'd2;
      e.mem_wr    = 1'b1;
      e.mem_addr  = w * 4;
      e.mem_wstrb = strb;
      e.mem_wdata = data;
      e.rdata     = 32'h0;
    end
  endtask

  // Acts as CPU and as memory (answering after d cycles of mem_req); starts/ends #1 after a posedge.
  task automatic run_access(input bit wr, input logic [1:0] ws, input logic [31:0] addr,
                            input logic [31:0] wdata, input int d, output obs_t o);
    int cyc = 0;
    int pend = -1;
    int unsigned w;
    logic [31:0] tmp;
    o = '0;
    dcache_addr  = addr;
    dcache_wdata = wdata;
    dcache_ws    = ws;
    dcache_wr    = wr;
    dcache_req   = 1'b1;
    while (o.got_rdy !== 1'b1 && cyc < 60) begin
      @(posedge clock); #1;
      cyc++;
      mem_rdy = 1'b0;
      if (dcache_rdy === 1'b1) begin
        o.got_rdy    = 1'b1;
        o.cycles     = 8'(cyc);
        o.rdata      = dcache_rdata;
        o.req_at_rdy = mem_req;
        dcache_req   = 1'b0;
      end else if (mem_req === 1'b1) begin
        if (o.mem_seen !== 1'b1) begin
          o.mem_seen  = 1'b1;
          o.mem_first = 8'(cyc);
          o.mem_wr    = mem_wr;
          o.mem_addr  = mem_addr;
          if (mem_wr === 1'b1) begin
            o.mem_wstrb = mem_wstrb;
            o.mem_wdata = mem_wdata;
          end
          pend = cyc + d - 1;
        end
        if (cyc == pend) begin
          w = mem_addr >> 2;
          tmp = phys_mem.exists(w) ? phys_mem[w] : 32'h0;
          if (mem_wr === 1'b1) begin
            for (int i = 0; i < 4; i++)
              if (mem_wstrb[i]) tmp[i*8 +: 8] = mem_wdata[i*8 +: 8];
            phys_mem[w] = tmp;
          end else begin
            mem_rdata = tmp;
          end
          mem_rdy = 1'b1;
        end
      end
    end
    mem_rdy    = 1'b0;
    dcache_req = 1'b0;
    if (o.got_rdy === 1'b1) begin
      @(posedge clock); #1;
      o.after_ok = (dcache_rdy === 1'b0) && (dcache_rdata === o.rdata);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({dcache_rdy, dcache_rdata, mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy=%0b rdata=%h req=%0b wr=%0b addr=%h wdata=%h strb=%b, want all zero",
               dcache_rdy, dcache_rdata, mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb);
    end
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if ({dcache_rdy, mem_req} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_after_reset: rdy=%0b mem_req=%0b, want 0 0", dcache_rdy, mem_req);
    end
  endtask

  task automatic test_load_miss_hit();
    obs_t e, o;
    ref_mem[32'h401]  = 32'hDEAD_BEEF;
    phys_mem[32'h401] = 32'hDEAD_BEEF;
    model_access(1'b0, 2'b10, 32'h1004, 32'h0, 3, e);
    run_access(1'b0, 2'b10, 32'h1004, 32'h0, 3, o);
    vectors++;
    if (o !== e || o.rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL load_miss_1004: got %s ; want %s", fmt(o), fmt(e));
    end
    model_access(1'b0, 2'b10, 32'h1004, 32'h0, 3, e);
    run_access(1'b0, 2'b10, 32'h1004, 32'h0, 3, o);
    vectors++;
    if (o !== e || o.cycles !== 8'd2 || o.mem_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL load_hit_1004: got %s ; want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_store();
    obs_t e, o;
    model_access(1'b1, 2'b00, 32'h1006, 32'h0000_005A, 2, e);
    run_access(1'b1, 2'b00, 32'h1006, 32'h0000_005A, 2, o);
    vectors++;
    if (o !== e || o.mem_wstrb !== 4'b0100 || o.mem_wdata !== 32'h5A5A_5A5A) begin
      miscompares++;
      $display("FAIL store_byte_1006: got %s ; want %s", fmt(o), fmt(e));
    end
    model_access(1'b0, 2'b10, 32'h1004, 32'h0, 2, e);
    run_access(1'b0, 2'b10, 32'h1004, 32'h0, 2, o);
    vectors++;
    if (o !== e || o.rdata !== 32'hDE5A_BEEF) begin
      miscompares++;
      $display("FAIL load_merged_1004: got %s ; want %s", fmt(o), fmt(e));
    end
    model_access(1'b1, 2'b01, 32'h2002, 32'h0000_1234, 1, e);
    run_access(1'b1, 2'b01, 32'h2002, 32'h0000_1234, 1, o);
    vectors++;
    if (o !== e || o.mem_wstrb !== 4'b1100 || o.mem_wdata !== 32'h1234_1234) begin
      miscompares++;
      $display("FAIL store_half_2002: got %s ; want %s", fmt(o), fmt(e));
    end
    model_access(1'b0, 2'b10, 32'h2000, 32'h0, 2, e);
    run_access(1'b0, 2'b10, 32'h2000, 32'h0, 2, o);
    vectors++;
    if (o !== e || o.mem_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL load_no_allocate_2000: got %s ; want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_conflict();
    obs_t e, o;
    logic [31:0] seq [3] = '{32'h1004, 32'h1104, 32'h1004};
    for (int i = 0; i < 3; i++) begin
      model_access(1'b0, 2'b10, seq[i], 32'h0, 2, e);
      run_access(1'b0, 2'b10, seq[i], 32'h0, 2, o);
      vectors++;
      if (o !== e || (i > 0 && o.mem_seen !== 1'b1)) begin
        miscompares++;
        $display("FAIL conflict_%0d_%h: got %s ; want %s", i, seq[i], fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    int cyc = 0;
    dcache_addr = 32'h3008;
    dcache_ws   = 2'b10;
    dcache_wr   = 1'b0;
    dcache_req  = 1'b1;
    while (mem_req !== 1'b1 && cyc < 10) begin
      @(posedge clock); #1;
      cyc++;
    end
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_reach_mem_rd: mem_req=%0b after %0d cycles, want 1", mem_req, cyc);
    end
    reset = 1'b1;
    dcache_req = 1'b0;
    #1;
    vectors++;
    if ({mem_req, dcache_rdy} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_mid_drop: mem_req=%0b rdy=%0b, want 0 0", mem_req, dcache_rdy);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    resident.delete();
    exp_hits = 0;
    exp_misses = 0;
    model_access(1'b0, 2'b10, 32'h1004, 32'h0, 2, e);
    run_access(1'b0, 2'b10, 32'h1004, 32'h0, 2, o);
    vectors++;
    if (o !== e || o.mem_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_invalidate: got %s ; want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_random();
    obs_t e, o;
    bit wr;
    logic [1:0] ws;
    logic [31:0] addr, wdata;
    int d;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        mem_rdy = 1'b1;
        @(posedge clock); #1;
        mem_rdy = 1'b0;
        vectors++;
        if ({dcache_rdy, mem_req} !== 2'b00) begin
          miscompares++;
          $display("FAIL stray_mem_rdy_%0d: rdy=%0b mem_req=%0b, want 0 0", n, dcache_rdy, mem_req);
        end
      end
      wr    = ($urandom_range(0, 2) == 0);
      ws    = 2'($urandom_range(0, 3));
      addr  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      wdata = $urandom;
      d     = $urandom_range(1, 4);
      model_access(wr, ws, addr, wdata, d, e);
      run_access(wr, ws, addr, wdata, d, o);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL random_%0d wr=%0b ws=%0d addr=%h: got %s ; want %s", n, wr, ws, addr, fmt(o), fmt(e));
      end
    end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    obs_t e, o;
    logic [31:0] seq [6] = '{32'h500, 32'h500, 32'h502, 32'h608, 32'h608, 32'h501};
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    resident.delete();
    exp_hits = 0;
    exp_misses = 0;
    vectors++;
    if ({stat_hits, stat_misses} !== 64'h0) begin
      miscompares++;
      $display("FAIL stats_reset: hits=%0d misses=%0d, want 0 0", stat_hits, stat_misses);
    end
    for (int i = 0; i < 6; i++) begin
      model_access(i == 5, 2'b00, seq[i], 32'hA5, 1, e);
      run_access(i == 5, 2'b00, seq[i], 32'hA5, 1, o);
    end
    vectors++;
    if (stat_hits !== 32'(exp_hits) || stat_misses !== 32'(exp_misses) ||
        stat_hits !== 32'd3 || stat_misses !== 32'd2) begin
      miscompares++;
      $display("FAIL stats_count: hits=%0d misses=%0d, want 3 2", stat_hits, stat_misses);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_miss_hit();
    test_store();
    test_conflict();
    test_reset_mid();
    test_random();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
